// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: built-in self-test controller for a 32x8 single-port
// synchronous RAM. After a start pulse it writes a pattern to every
// address, reads it back and compares. It then repeats this with the
// inverted pattern and reports pass/fail, the first failing address and
// data, and a saturating error count.
//
// Ports:
//   clk, rst     clock (posedge), synchronous active-high reset
//   start        single-cycle run request; ignored while busy
//   mem_addr     RAM address
//   mem_wdata    RAM write data
//   mem_wr_rd    1 = write, 0 = read
//   mem_rdata    RAM registered read data, valid the cycle after a read
//   busy         test in progress
//   done         level; results valid until the next start or rst
//   pass         1 iff no mismatches were seen (valid with done)
//   fail_addr    address of the first mismatch
//   fail_data    data read at the first mismatch
//   err_count    mismatch count, saturating at 255
module ram_bist_ctrl #(
  parameter int                ADDR_W  = 5,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [7:0]        err_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR_A = 3'd1;
  localparam logic [2:0] S_RD_A = 3'd2;
  localparam logic [2:0] S_WR_B = 3'd3;
  localparam logic [2:0] S_RD_B = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Pass A writes {0,a}^PATTERN, pass B writes its complement.
  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a,
                                                 input logic pass_b);
    logic [DATA_W-1:0] v;
    v = DATA_W'(a) ^ PATTERN;
    return pass_b ? ~v : v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [7:0]        err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_rd_q, wr_rd_d;
  logic              cmp_vld_p1_q, cmp_vld_p1_d;
  logic [ADDR_W-1:0] cmp_addr_p1_q, cmp_addr_p1_d;
  logic              cmp_b_p1_q, cmp_b_p1_d;
  logic              mismatch;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    drain_d       = drain_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
    err_d         = err_q;
    cmp_vld_p1_d  = 1'b0;
    cmp_addr_p1_d = addr_q;
    cmp_b_p1_d    = (state_q == S_RD_B);

    // Compare stage: read data for the address issued last cycle.
    mismatch = cmp_vld_p1_q && (mem_rdata != exp_data(cmp_addr_p1_q, cmp_b_p1_q));
    if (mismatch) begin
      err_d = sat_inc(err_q);
      if (err_q == 8'd0) begin
        fail_addr_d = cmp_addr_p1_q;
        fail_data_d = mem_rdata;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WR_A;
          addr_d      = '0;
          drain_d     = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = 8'd0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      S_WR_A, S_WR_B: begin
        // Counter wraps to 0 exactly as the pass switches to reading.
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == '1) begin
          state_d = (state_q == S_WR_A) ? S_RD_A : S_RD_B;
        end
      end
      S_RD_A, S_RD_B: begin
        if (!drain_q) begin
          cmp_vld_p1_d = 1'b1;
          addr_d       = addr_q + ADDR_W'(1);
          if (addr_q == '1) drain_d = 1'b1;
        end else begin
          // Drain cycle: no new read, last compare (address max) lands now.
          drain_d = 1'b0;
          if (state_q == S_RD_A) begin
            state_d = S_WR_B;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 8'd0);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    wr_rd_d = (state_d == S_WR_A) || (state_d == S_WR_B);
    wdata_d = wr_rd_d ? exp_data(addr_d, state_d == S_WR_B) : '0;
  end

  // Stage p0 -> p1: bus outputs, run status and compare pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      drain_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
      err_q         <= 8'd0;
      wdata_q       <= '0;
      wr_rd_q       <= 1'b0;
      cmp_vld_p1_q  <= 1'b0;
      cmp_addr_p1_q <= '0;
      cmp_b_p1_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      drain_q       <= drain_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
      err_q         <= err_d;
      wdata_q       <= wdata_d;
      wr_rd_q       <= wr_rd_d;
      cmp_vld_p1_q  <= cmp_vld_p1_d;
      cmp_addr_p1_q <= cmp_addr_p1_d;
      cmp_b_p1_q    <= cmp_b_p1_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr_rd = wr_rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr_rd;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy, done, pass;
  logic [4:0] fail_addr;
  logic [7:0] fail_data;
  logic [7:0] err_count;

  ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .PATTERN(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_rd(mem_wr_rd),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pass_e;
    int err_e;
    int fa_e;
    int fd_e;
  } res_t;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Fault injection: 0 = none, 1 = stuck bit at one address, 2 = reads return 0
  int   fmode = 0;
  int   f_addr = 0;
  int   f_bit = 0;
  logic f_val = 1'b0;

  logic [7:0] ram [32];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_a(input int a);
    return 8'(a) ^ 8'hA5;
  endfunction

  function automatic logic [7:0] faulty(input int a, input logic [7:0] w);
    logic [7:0] r;
    r = w;
    if (fmode == 2) r = 8'h00;
    else if (fmode == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  // Reference: walk both passes over all addresses, read what a RAM with
  // the configured fault would return, and tally results.
  function automatic res_t model_run();
    res_t r;
    logic [7:0] w, rd;
    r.err_e = 0; r.fa_e = 0; r.fd_e = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 32; a++) begin
        w  = (p == 0) ? exp_a(a) : ~exp_a(a);
        rd = faulty(a, w);
        if (rd != w) begin
          if (r.err_e == 0) begin r.fa_e = a; r.fd_e = int'(rd); end
          r.err_e = (r.err_e == 255) ? 255 : r.err_e + 1;
        end
      end
    end
    r.pass_e = (r.err_e == 0) ? 1 : 0;
    return r;
  endfunction

  // RAM model with registered read data
  always @(posedge clk) begin
    if (mem_wr_rd) ram[mem_addr] <= mem_wdata;
    else           mem_rdata     <= faulty(int'(mem_addr), ram[mem_addr]);
  end

  // Monitor: bus trace against the run timeline, results against scoreboard
  int   off = 0;
  int   trace_err = 0;
  int   trace_first = -1;
  int   idle_writes = 0;
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;

  always @(posedge clk) begin
    int  ew, ea;
    bit  chk_a;
    res_t e;
    #1;
    if (busy !== 1'b1 && mem_wr_rd === 1'b1) idle_writes++;
    if (busy === 1'b1) begin
      if (!busy_prev) begin off = 0; trace_err = 0; trace_first = -1; end
      ew = 0; ea = 0; chk_a = 1'b1;
      if      (off < 32)  begin ew = 1; ea = off;      end
      else if (off < 64)  begin ew = 0; ea = off - 32; end
      else if (off == 64) begin ew = 0; chk_a = 1'b0;  end
      else if (off < 97)  begin ew = 1; ea = off - 65; end
      else if (off < 129) begin ew = 0; ea = off - 97; end
      else                begin ew = 0; chk_a = 1'b0;  end
      if (int'(mem_wr_rd) != ew || (chk_a && int'(mem_addr) != ea) ||
          (ew == 1 && mem_wdata != ((off < 32) ? exp_a(ea) : ~exp_a(ea)))) begin
        trace_err++;
        if (trace_first < 0) trace_first = off;
      end
      off++;
    end
    if (done === 1'b1 && !done_prev) begin
      check("run_length", off, 130);
      check("bus_trace_errors", trace_err, 0);
      if (trace_err != 0) $display("  first bad bus cycle offset %0d", trace_first);
      if (exp_q.size() == 0) begin
        check("scoreboard_entry_present", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("pass", int'(pass), e.pass_e);
        check("err_count", int'(err_count), e.err_e);
        check("fail_addr", int'(fail_addr), e.fa_e);
        check("fail_data", int'(fail_data), e.fd_e);
      end
    end
    busy_prev = (busy === 1'b1);
    done_prev = (done === 1'b1);
  end

  task automatic run_test(input int mode, input int fa, input int fb,
                          input logic fv, input bit spam);
    res_t r;
    bit   got;
    fmode = mode; f_addr = fa; f_bit = fb; f_val = fv;
    r = model_run();
    exp_q.push_back(r);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_done_clr", int'(done), 0);
    check("start_err_clr", int'(err_count), 0);
    check("first_wr_addr", int'(mem_addr), 0);
    check("first_wr_data", int'(mem_wdata), 8'hA5);
    check("first_wr_rd", int'(mem_wr_rd), 1);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
      start = spam ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    start = 1'b0;
    check("done_seen", int'(got), 1);
    repeat (3) @(negedge clk);
    if (got) check("done_hold", int'(done), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_wr_rd", int'(mem_wr_rd), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_wr_rd", int'(mem_wr_rd), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    check("rst_fail_addr", int'(fail_addr), 0);
    check("rst_fail_data", int'(fail_data), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_test(0, 0, 0, 1'b0, 1'b0);            // fault-free
    run_test(1, 5, 0, 1'b0, 1'b0);            // mem[5] bit0 stuck at 0
    run_test(2, 0, 0, 1'b0, 1'b1);            // all reads zero, start spam
    run_test(1, 31, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
    for (int k = 0; k < 4; k++)
      run_test(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset abort in pass-A read phase at address 10
    fmode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (42) @(negedge clk);
    check("abort_addr", int'(mem_addr), 10);
    check("abort_is_read", int'(mem_wr_rd), 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_wr_rd", int'(mem_wr_rd), 0);
    check("abort_err", int'(err_count), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_writes", idle_writes, 0);

    run_test(0, 0, 0, 1'b0, 1'b0);            // clean run after abort
    check("idle_writes", idle_writes, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
Initiator-side controller for the 32x8 single-port synchronous RAM: drives its addr/data_in/wr_rd port and consumes its registered data_out. On a start pulse it runs a two-pass write/read-compare test over every address and reports pass/fail, first failing address/data and error count. It sits beside the RAM in memory test builds and is the bus master for the RAM's read/write interface.

Parameters:
ADDR_W, 5, RAM address width; depth = 2**ADDR_W (32)
DATA_W, 8, RAM data width
PATTERN, 8'hA5, seed XORed with the address to form pass-A write data

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a test run
mem_addr  output  ADDR_W  address to RAM addr
mem_wdata  output  DATA_W  write data to RAM data_in
mem_wr_rd  output  1  1 = write, 0 = read, to RAM wr_rd
mem_rdata  input  DATA_W  RAM data_out, registered, valid the cycle after a read is issued
busy  output  1  test in progress
done  output  1  level; test finished, results valid; cleared by next accepted start or rst
pass  output  1  valid when done; 1 iff err_count == 0
fail_addr  output  ADDR_W  address of first mismatch
fail_data  output  DATA_W  data read at first mismatch
err_count  output  8  mismatch count, saturates at 255

Behaviour:
- Reset: rst high at posedge -> state IDLE; mem_addr=0, mem_wdata=0, mem_wr_rd=0, busy=0, done=0, pass=0, fail_addr=0, fail_data=0, err_count=0, compare pipeline cleared. Reset mid-run aborts immediately, no further writes issued.
- All outputs registered. mem_wr_rd is 0 in every state except WR_A/WR_B.
- Expected data: expA(a) = {0,a} ^ PATTERN; expB(a) = ~expA(a).
- States: IDLE -> WR_A -> RD_A -> WR_B -> RD_B -> DONE.
- IDLE: start=1 sampled -> WR_A, addr counter=0, busy=1, done=0, err_count=0, fail_* = 0.
- WR_A: each cycle drive mem_addr=a, mem_wdata=expA(a), mem_wr_rd=1; a increments; after a=31 -> RD_A with a=0.
- RD_A: each cycle drive mem_addr=a, mem_wr_rd=0; a 0..31 over 32 cycles, then one drain cycle (no new read) -> WR_B.
- Compare pipeline: read issued in cycle k with address a -> cmp_valid and cmp_addr=a registered; in cycle k+1 mem_rdata is compared with expected(cmp_addr) for the current pass. Mismatch: err_count += 1 (saturating at 255); if err_count was 0, capture fail_addr=cmp_addr and fail_data=mem_rdata.
- WR_B / RD_B: identical to WR_A / RD_A using expB; RD_B drain -> DONE.
- DONE: busy=0, done=1, pass=(err_count==0); outputs hold; start=1 -> new run as from IDLE.
- start while busy is ignored. Run length: 130 busy cycles (32+33+32+33); done rises on the 131st edge after start is sampled.
- Address counter wraps at 31 -> 0 on pass transitions, never overruns.

Test Plan:
- Fault-free RAM model, reset, then start pulse -> first write cycle addr=0 wdata=A5 wr_rd=1; addr=31 wdata=BA; pass-B addr=0 wdata=5A; done=1 exactly 130 cycles after busy rises; pass=1, err_count=0.
- RAM model with mem[5] bit0 stuck at 0 -> pass A is clean (A0 expected); pass B reads 5E vs 5F; done: pass=0, err_count=1, fail_addr=5, fail_data=5E.
- RAM model returning 00 for every read -> first mismatch fail_addr=0, fail_data=00; err_count=64; pass=0.
- Reset asserted during RD_A, at address 10 -> next cycle busy=0, done=0, mem_wr_rd=0, err_count=0; no write issued afterwards; a new start runs a full clean test.
- start pulsed repeatedly while busy -> ignored; run length is still 130 cycles. start while done -> done clears next cycle, new run begins with err_count=0.
- Read-latency check: the bench asserts that each compare uses the address issued on the previous cycle, and that the drain cycle compares address 31.
